// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line fill stage.
// Line geometry is fixed here so every user agrees on the line layout.
package cache_pkg;

  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned CNT_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFFSET_BITS    = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    DONE      = 2'd3
  } fill_state_t;

  // Word 0 occupies the least significant DATA_W bits.
  typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << OFFSET_BITS;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Controller request/response and main-memory bus of the line fill stage.
// slave: the fill block itself; master: the controller and memory around it.
interface cache_line_fill_if;
  import cache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wb;
  logic [ADDR_W-1:0] req_wb_addr;
  line_t             req_wb_line;
  logic              resp_valid;
  line_t             resp_line;
  logic              mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_line, mem_rdata, mem_valid,
    output req_ready, resp_valid, resp_line, mem_rd, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_wb, req_wb_addr, req_wb_line, mem_rdata, mem_valid,
    input  req_ready, resp_valid, resp_line, mem_rd, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_line_fill.sv
// Miss handler: optional word-by-word victim writeback, then word-by-word line fetch,
// then a single-cycle response carrying the assembled line.
module cache_line_fill
  import cache_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  cache_line_fill_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

  fill_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fill_base_q, wb_base_q;
  line_t             victim_q;
  line_t             line_q;
  logic              accept;
  logic              cnt_last;
  logic [ADDR_W-1:0] word_off;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign word_off = ADDR_W'({cnt_q, 2'b00});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = bus.req_wb ? WRITEBACK : FILL;
          cnt_d   = '0;
        end
      end
      WRITEBACK: begin
        if (bus.mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_base_q <= '0;
      wb_base_q   <= '0;
      victim_q    <= '0;
      line_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fill_base_q <= line_align(bus.req_addr);
        wb_base_q   <= line_align(bus.req_wb_addr);
        victim_q    <= bus.req_wb_line;
      end
      if ((state_q == FILL) && bus.mem_valid) begin
        line_q[cnt_q] <= bus.mem_rdata;
      end
    end
  end

  // All memory-side outputs decode registered state only; mem_valid never reaches them.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      WRITEBACK: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_base_q + word_off;
        bus.mem_wdata = victim_q[cnt_q];
      end
      FILL: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = fill_base_q + word_off;
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_line  = line_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: clean/dirty misses, stalls, address wrap,
// reset mid-fill and back-to-back requests against a simple address-keyed memory.
module tb_cache_line_fill;
  import cache_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  logic [DATA_W-1:0] rd_base;
  int tests;
  int fails;

  cache_line_fill_if bus ();

  cache_line_fill u_dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Read data encodes the word index of the address, so misordered reads show up.
  assign bus.mem_rdata = rd_base + {29'b0, bus.mem_addr[4:2]};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic [31:0] faddr, input logic [31:0] exp_fbase,
                        input logic wb, input logic [31:0] waddr,
                        input logic [31:0] exp_wbase, input logic [31:0] vbase,
                        input logic [31:0] rbase, input int stall, input int exp_done,
                        input bit hold_req);
    line_t victim;
    line_t exp_line;
    int    phase;
    int    idx;
    int    cyc;
    bit    mv;
    bit    done;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      victim[i]   = vbase + 32'(i);
      exp_line[i] = rbase + 32'(i);
    end
    check("ready_before_req", {255'b0, bus.req_ready}, 256'd1);
    rd_base         = rbase;
    bus.req_addr    = faddr;
    bus.req_wb      = wb;
    bus.req_wb_addr = waddr;
    bus.req_wb_line = victim;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid = hold_req;
    phase = wb ? 1 : 2;
    idx   = 0;
    cyc   = 1;
    done  = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (phase == 3) begin
        check("resp_valid_done", {255'b0, bus.resp_valid}, 256'd1);
        check("strobes_done", {254'b0, bus.mem_rd, bus.mem_we}, 256'd0);
        check("resp_line", bus.resp_line, exp_line);
        if (exp_done > 0) check("done_cycle", 256'(cyc), 256'(exp_done));
        done = 1'b1;
        break;
      end
      check("busy_ready", {255'b0, bus.req_ready}, 256'd0);
      check("busy_resp", {255'b0, bus.resp_valid}, 256'd0);
      if (phase == 1) begin
        check("wb_strobes", {254'b0, bus.mem_rd, bus.mem_we}, 256'd1);
        check("wb_addr", 256'(bus.mem_addr), 256'(exp_wbase + 32'(4 * idx)));
        check("wb_data", 256'(bus.mem_wdata), 256'(victim[idx]));
      end else begin
        check("rd_strobes", {254'b0, bus.mem_rd, bus.mem_we}, 256'd2);
        check("rd_addr", 256'(bus.mem_addr), 256'(exp_fbase + 32'(4 * idx)));
      end
      mv = (stall <= 1) || (cyc % stall == 0);
      bus.mem_valid = mv;
      tick();
      cyc++;
      if (mv) begin
        idx++;
        if (idx == WORDS_PER_LINE) begin
          idx = 0;
          phase++;
        end
      end
    end
    if (!done) check("txn_timeout", 256'd0, 256'd1);
    bus.mem_valid = 1'b1;  // must be ignored in DONE
    tick();
    bus.mem_valid = 1'b0;
    check("resp_pulse_end", {255'b0, bus.resp_valid}, 256'd0);
    check("ready_after_done", {255'b0, bus.req_ready}, 256'd1);
    check("idle_strobes", {254'b0, bus.mem_rd, bus.mem_we}, 256'd0);
  endtask

  initial begin
    bit   saw_resp;
    line_t exp_line;
    tests           = 0;
    fails           = 0;
    rd_base         = '0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wb      = 1'b0;
    bus.req_wb_addr = '0;
    bus.req_wb_line = '0;
    bus.mem_valid   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", {255'b0, bus.req_ready}, 256'd1);
    check("rst_resp_valid", {255'b0, bus.resp_valid}, 256'd0);
    check("rst_resp_line", bus.resp_line, 256'd0);
    check("rst_strobes", {254'b0, bus.mem_rd, bus.mem_we}, 256'd0);
    check("rst_addr", 256'(bus.mem_addr), 256'd0);
    check("rst_wdata", 256'(bus.mem_wdata), 256'd0);

    // Clean miss, memory always ready.
    do_txn(32'h0000_1014, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 32'h0,
           32'hA0, 1, 9, 1'b0);
    // Dirty miss: eight writes then eight reads.
    do_txn(32'h0000_3000, 32'h0000_3000, 1'b1, 32'h0000_2000, 32'h0000_2000, 32'h10,
           32'h300, 1, 17, 1'b0);
    // Stalled memory, completion every third cycle, unaligned victim address.
    do_txn(32'h0000_501C, 32'h0000_5000, 1'b1, 32'h0000_4008, 32'h0000_4000, 32'h55,
           32'h700, 3, -1, 1'b0);
    // Top-of-memory line: no carry past the line.
    do_txn(32'hFFFF_FFE0, 32'hFFFF_FFE0, 1'b0, 32'h0, 32'h0, 32'h0,
           32'hC0, 1, 9, 1'b0);

    // Idle cycles: resp_line holds the last fetched line.
    tick();
    tick();
    for (int i = 0; i < WORDS_PER_LINE; i++) exp_line[i] = 32'hC0 + 32'(i);
    check("resp_line_hold", bus.resp_line, exp_line);

    // Reset after three fill words.
    rd_base       = 32'h900;
    bus.req_addr  = 32'h0000_6000;
    bus.req_wb    = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_valid = 1'b1;
    tick();
    tick();
    tick();
    check("mid_fill_addr", 256'(bus.mem_addr), 256'h600C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_rst_rd", {255'b0, bus.mem_rd}, 256'd0);
    check("post_rst_ready", {255'b0, bus.req_ready}, 256'd1);
    check("post_rst_resp", {255'b0, bus.resp_valid}, 256'd0);
    check("post_rst_line", bus.resp_line, 256'd0);
    saw_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    bus.mem_valid = 1'b0;
    check("no_resp_after_rst", {255'b0, saw_resp}, 256'd0);
    do_txn(32'h0000_6000, 32'h0000_6000, 1'b0, 32'h0, 32'h0, 32'h0,
           32'h910, 1, 9, 1'b0);

    // req_valid held high across two transactions.
    do_txn(32'h0000_7004, 32'h0000_7000, 1'b1, 32'h0000_8000, 32'h0000_8000, 32'h20,
           32'hB00, 1, 17, 1'b1);
    do_txn(32'h0000_9000, 32'h0000_9000, 1'b0, 32'h0, 32'h0, 32'h0,
           32'hD00, 2, -1, 1'b1);
    bus.req_valid = 1'b0;
    tick();
    check("final_idle", {255'b0, bus.req_ready}, 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Memory-side stage directly downstream of the cache controller.
- On a miss, the controller hands this block a line address, plus an optional dirty victim line.
- Block writes the victim back word by word, fetches the new line word by word from main memory, then returns the assembled line with a one-cycle done pulse.
- One line transaction in flight at a time.

Parameters:
- WORDS_PER_LINE, 8, 32-bit words per cache line; power of two, >=2.
- DATA_W, 32, memory word width in bits.
- ADDR_W, 32, byte address width.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  controller requests a line transaction.
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready.
- req_addr  in  ADDR_W  fill line address; low log2(WORDS_PER_LINE)+2 bits ignored (forced 0).
- req_wb  in  1  victim is dirty; write it back before filling.
- req_wb_addr  in  ADDR_W  victim line address; low offset bits ignored.
- req_wb_line  in  WORDS_PER_LINE*DATA_W  victim data, word 0 in LSBs.
- resp_valid  out  1  one-cycle pulse: fill complete, resp_line valid.
- resp_line  out  WORDS_PER_LINE*DATA_W  fetched line, word 0 in LSBs; holds until next fill writes it.
- mem_rd  out  1  read request to main memory.
- mem_we  out  1  write request to main memory.
- mem_addr  out  ADDR_W  word-aligned byte address of current access.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid when mem_valid.
- mem_valid  in  1  memory completed current access (read data present / write accepted).

Behaviour:
- States: IDLE, WRITEBACK, FILL, DONE.
- Reset values: state IDLE, word counter 0, resp_valid 0, resp_line 0, mem_rd 0, mem_we 0, mem_addr 0, mem_wdata 0. Captured request registers 0.
- Reset mid-transaction returns to IDLE on that edge. No memory strobe is asserted in the following cycle. Partial line is discarded.
- IDLE: req_ready=1.
  - On accept, latch aligned addresses, req_wb and victim line; counter := 0.
  - Next state is WRITEBACK if req_wb, else FILL.
  - req_valid in any other state is ignored, not queued.
- WRITEBACK:
  - Outputs: mem_we=1, mem_addr = wb_base + 4*cnt (mod 2^ADDR_W), mem_wdata = victim word[cnt].
  - Each cycle with mem_valid: cnt++.
  - On mem_valid with cnt==WORDS_PER_LINE-1: cnt := 0, go FILL.
- FILL:
  - Outputs: mem_rd=1, mem_addr = fill_base + 4*cnt (mod 2^ADDR_W).
  - Each cycle with mem_valid: resp_line word[cnt] := mem_rdata, cnt++.
  - On the last word: go DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE (req_ready=1 the next cycle).
- mem_rd and mem_we are never both 1. Both are 0 in IDLE and DONE.
- mem_addr and mem_wdata depend only on registered state; no combinational path from mem_valid.
- mem_valid in IDLE or DONE is ignored.
- Stalls: memory may hold mem_valid low arbitrarily. Block holds address, data and strobe stable until mem_valid.
- Latency with mem_valid tied high, accept at cycle 0:
  - no writeback: resp_valid at cycle WORDS_PER_LINE+1;
  - with writeback: resp_valid at cycle 2*WORDS_PER_LINE+1.
- Counter width is log2(WORDS_PER_LINE) and wraps to 0 after the last word.

Decomposition:
- Shared package cache_pkg holds:
  - WORDS_PER_LINE, OFFSET_BITS = log2(WORDS_PER_LINE)+2;
  - fill_state_t enum (IDLE, WRITEBACK, FILL, DONE);
  - line_t packed array type.
- No sub-module. Single FSM plus counter; datapath is trivial.

Test Plan:
- Clean miss:
  - Stimulus: req_addr=0x0000_1014, req_wb=0, memory returns 0xA0+i for word i with mem_valid always high.
  - Response: mem_addr 0x1000,0x1004..0x101C; resp_valid at cycle 9; resp_line words 0xA0..0xA7.
- Dirty miss:
  - Stimulus: req_wb=1, req_wb_addr=0x2000, victim words 0x10..0x17, fill addr 0x3000.
  - Response: eight writes 0x2000..0x201C with those data, then eight reads 0x3000..; resp_valid at cycle 17; never mem_rd&&mem_we.
- Stalled memory:
  - Stimulus: mem_valid high only every 3rd cycle.
  - Response: mem_addr/mem_wdata stable between completions; correct line; resp_valid pulse exactly one cycle.
- Address wrap:
  - Stimulus: req_addr=0xFFFF_FFE0.
  - Response: reads 0xFFFF_FFE0..0xFFFF_FFFC, no carry beyond.
- Reset mid-FILL:
  - Stimulus: assert reset after 3 words.
  - Response: next cycle mem_rd=0, req_ready=1, resp_valid never asserted. A following request completes normally.
- Back-to-back and busy:
  - Stimulus: req_valid held high through a transaction.
  - Response: second request is not accepted until req_ready returns 1 after DONE.
